delay_timer_bank: RTL and testbench

//  Bank of NCH independent programmable delay timers, the parametrised successor of the fixed-N DELAY block.

---
 rtl/delay_pkg.sv | 23 ++
 rtl/delay_channel.sv | 100 ++++++++++
 rtl/delay_timer_bank.sv | 80 ++++++++
 tb/tb_delay_timer_bank.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared types and helpers for the delay timer bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: channel FSM state enum, default counter width, and a clog2
// helper that never returns 0 so a single-channel bank still gets a
// 1-bit channel select.
package delay_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } dly_state_t;

   localparam int DEF_CBITS = 18;

   // Width of a channel index; at least one bit even when n == 1.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/delay_channel.sv
// One programmable delay timer: counts enabled cycles, pulses o_sig every period+1 of them.
// Latency: all outputs registered, 1 cycle after the deciding edge.
// Backpressure: none; i_wr is always absorbed in the cycle it is presented.
//
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_en                    count enable (low = hold)
//   i_start                 enter RUN with cnt := 0, latching i_oneshot
//   i_oneshot               1 = stop in DONE after the first expiry
//   i_wr, i_wr_period       validated period write for this channel
//   o_sig, o_flg, o_err     expiry pulse, window-open level, period-violation pulse
module delay_channel
   import delay_pkg::*;
#(
   parameter int CBITS     = DEF_CBITS,
   parameter int DEFAULT_N = 200000
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_start,
   input  logic             i_oneshot,
   input  logic             i_wr,
   input  logic [CBITS-1:0] i_wr_period,
   output logic             o_sig,
   output logic             o_flg,
   output logic             o_err
);

   dly_state_t       r_state, w_state_nx;
   logic [CBITS-1:0] r_cnt, w_cnt_nx;
   logic [CBITS-1:0] r_period, w_period_nx;
   logic             r_oneshot, w_oneshot_nx;
   logic             r_sig, w_sig_nx;
   logic             r_flg, w_flg_nx;
   logic             r_err, w_err_nx;
   logic             w_wrap;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_period  <= CBITS'(DEFAULT_N);
         r_oneshot <= 1'b0;
         r_sig     <= 1'b0;
         r_flg     <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         r_period  <= w_period_nx;
         r_oneshot <= w_oneshot_nx;
         r_sig     <= w_sig_nx;
         r_flg     <= w_flg_nx;
         r_err     <= w_err_nx;
      end
   end

   always_comb begin
      w_state_nx   = r_state;
      w_cnt_nx     = r_cnt;
      w_oneshot_nx = r_oneshot;
      w_sig_nx     = 1'b0;
      w_err_nx     = 1'b0;
      // A write always lands; the wrap decision below still uses the old period.
      w_period_nx  = i_wr ? i_wr_period : r_period;
      // >= rather than == so a write equal to the current count cannot
      // leave the counter stranded above its period.
      w_wrap       = i_en && (r_cnt >= r_period);

      if (i_start) begin
         // Start beats wrap and suppresses any violation check.
         w_state_nx   = RUN;
         w_cnt_nx     = '0;
         w_oneshot_nx = i_oneshot;
      end else if (r_state == RUN) begin
         if (w_wrap) begin
            w_cnt_nx = '0;
            w_sig_nx = 1'b1;
            if (r_oneshot) begin
               w_state_nx = DONE;
            end
         end else if (i_wr && (i_wr_period < r_cnt)) begin
            // Shrinking the period below the current count: restart the
            // count and flag it instead of waiting for a wrap that never comes.
            w_err_nx = 1'b1;
            w_cnt_nx = '0;
         end else if (i_en) begin
            w_cnt_nx = r_cnt + CBITS'(1);
         end
      end

      w_flg_nx = (w_state_nx == RUN) && (w_cnt_nx <= w_period_nx);
   end

   assign o_sig = r_sig;
   assign o_flg = r_flg;
   assign o_err = r_err;

endmodule

// File: rtl/delay_timer_bank.sv
// Bank of NCH independent delay timers with a validated valid/ready period-config port.
// Latency: outputs registered; config takes effect and cfg_err pulses 1 cycle after acceptance.
// Backpressure: o_cfg_ready low only until the first edge after reset, then always ready.
//
// Ports:
//   i_clk, i_rst                        clock, async active-high reset
//   i_en, i_oneshot, i_start [NCH]      per-channel controls
//   i_cfg_valid, i_cfg_ch, i_cfg_period period write request
//   o_cfg_ready, o_cfg_err              write handshake and rejection pulse
//   o_sig, o_flg, o_err [NCH]           per-channel timer outputs
module delay_timer_bank
   import delay_pkg::*;
#(
   parameter int NCH       = 4,
   parameter int CBITS     = DEF_CBITS,
   parameter int DEFAULT_N = 200000
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [NCH-1:0]              i_en,
   input  logic [NCH-1:0]              i_oneshot,
   input  logic [NCH-1:0]              i_start,
   input  logic                        i_cfg_valid,
   input  logic [clog2_min1(NCH)-1:0]  i_cfg_ch,
   input  logic [CBITS-1:0]            i_cfg_period,
   output logic                        o_cfg_ready,
   output logic                        o_cfg_err,
   output logic [NCH-1:0]              o_sig,
   output logic [NCH-1:0]              o_flg,
   output logic [NCH-1:0]              o_err
);

   logic           r_cfg_ready;
   logic           r_cfg_err;
   logic           w_accept;
   logic           w_bad;
   logic [NCH-1:0] w_wr;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cfg_ready <= 1'b0;
         r_cfg_err   <= 1'b0;
      end else begin
         r_cfg_ready <= 1'b1;
         r_cfg_err   <= w_accept && w_bad;
      end
   end

   always_comb begin
      w_accept = i_cfg_valid && r_cfg_ready;
      // Out-of-range channel (possible when NCH is not a power of two) or a
      // zero period is rejected without touching any channel.
      w_bad    = (int'(i_cfg_ch) >= NCH) || (i_cfg_period == '0);
      for (int i = 0; i < NCH; i++) begin
         w_wr[i] = w_accept && !w_bad && (int'(i_cfg_ch) == i);
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      delay_channel #(
         .CBITS     (CBITS),
         .DEFAULT_N (DEFAULT_N)
      ) u_ch (
         .i_clk       (i_clk),
         .i_rst       (i_rst),
         .i_en        (i_en[g]),
         .i_start     (i_start[g]),
         .i_oneshot   (i_oneshot[g]),
         .i_wr        (w_wr[g]),
         .i_wr_period (i_cfg_period),
         .o_sig       (o_sig[g]),
         .o_flg       (o_flg[g]),
         .o_err       (o_err[g])
      );
   end

   assign o_cfg_ready = r_cfg_ready;
   assign o_cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_delay_timer_bank.sv
// Directed bench for delay_timer_bank: table of per-cycle vectors plus hand sequences.
// Latency: expectations sampled 1 time unit after each rising edge.
// Backpressure: cfg_ready is checked, writes are only issued once it is high.
module tb_delay_timer_bank;

   localparam int NCH       = 3;
   localparam int CBITS     = 4;
   localparam int DEFAULT_N = 3;

   logic             i_clk;
   logic             i_rst;
   logic [NCH-1:0]   i_en;
   logic [NCH-1:0]   i_oneshot;
   logic [NCH-1:0]   i_start;
   logic             i_cfg_valid;
   logic [1:0]       i_cfg_ch;
   logic [CBITS-1:0] i_cfg_period;
   logic             o_cfg_ready;
   logic             o_cfg_err;
   logic [NCH-1:0]   o_sig;
   logic [NCH-1:0]   o_flg;
   logic [NCH-1:0]   o_err;

   int errors = 0;
   int checks = 0;

   delay_timer_bank #(
      .NCH       (NCH),
      .CBITS     (CBITS),
      .DEFAULT_N (DEFAULT_N)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_en         (i_en),
      .i_oneshot    (i_oneshot),
      .i_start      (i_start),
      .i_cfg_valid  (i_cfg_valid),
      .i_cfg_ch     (i_cfg_ch),
      .i_cfg_period (i_cfg_period),
      .o_cfg_ready  (o_cfg_ready),
      .o_cfg_err    (o_cfg_err),
      .o_sig        (o_sig),
      .o_flg        (o_flg),
      .o_err        (o_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [2:0] en;
      logic [2:0] os;
      logic [2:0] st;
      logic       cv;
      logic [1:0] ch;
      logic [3:0] per;
      logic [2:0] sig;
      logic [2:0] flg;
      logic [2:0] err;
      logic       cerr;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic [2:0] en, input logic [2:0] os, input logic [2:0] st,
                               input logic cv, input logic [1:0] ch, input logic [3:0] per,
                               input logic [2:0] sig, input logic [2:0] flg, input logic cerr);
      vec_t v;
      v.en = en; v.os = os; v.st = st; v.cv = cv; v.ch = ch; v.per = per;
      v.sig = sig; v.flg = flg; v.err = 3'b000; v.cerr = cerr;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   logic en_pat [7];

   initial begin
      // ---- vector table: ch0 periodic (default period 3), ch1 one-shot period 2,
      //      plus rejected writes that must not disturb ch0's spacing.
      //    en      os      st      cv  ch     per     sig     flg     cerr
      add(3'b001, 3'b000, 3'b001, 0, 2'd0, 4'd0, 3'b000, 3'b001, 0); // r0 start ch0
      add(3'b001, 3'b000, 3'b000, 0, 2'd0, 4'd0, 3'b000, 3'b001, 0); // r1
      add(3'b001, 3'b000, 3'b000, 1, 2'd3, 4'd5, 3'b000, 3'b001, 1); // r2 bad channel
      add(3'b001, 3'b000, 3'b000, 1, 2'd0, 4'd0, 3'b000, 3'b001, 1); // r3 zero period
      add(3'b001, 3'b000, 3'b000, 0, 2'd0, 4'd0, 3'b001, 3'b001, 0); // r4 sig
      add(3'b001, 3'b000, 3'b000, 0, 2'd0, 4'd0, 3'b000, 3'b001, 0); // r5
      add(3'b001, 3'b000, 3'b000, 0, 2'd0, 4'd0, 3'b000, 3'b001, 0); // r6
      add(3'b001, 3'b000, 3'b000, 0, 2'd0, 4'd0, 3'b000, 3'b001, 0); // r7
      add(3'b001, 3'b000, 3'b000, 0, 2'd0, 4'd0, 3'b001, 3'b001, 0); // r8 sig
      add(3'b001, 3'b000, 3'b000, 1, 2'd1, 4'd2, 3'b000, 3'b001, 0); // r9 ch1 period 2
      add(3'b011, 3'b010, 3'b010, 0, 2'd0, 4'd0, 3'b000, 3'b011, 0); // r10 start ch1 one-shot
      add(3'b011, 3'b010, 3'b000, 0, 2'd0, 4'd0, 3'b000, 3'b011, 0); // r11
      add(3'b011, 3'b010, 3'b000, 0, 2'd0, 4'd0, 3'b001, 3'b011, 0); // r12 ch0 sig
      add(3'b011, 3'b010, 3'b000, 0, 2'd0, 4'd0, 3'b010, 3'b001, 0); // r13 ch1 sig -> DONE
      add(3'b011, 3'b010, 3'b000, 0, 2'd0, 4'd0, 3'b000, 3'b001, 0); // r14 ch1 stays done
      add(3'b011, 3'b010, 3'b010, 0, 2'd0, 4'd0, 3'b000, 3'b011, 0); // r15 rearm ch1
      add(3'b011, 3'b010, 3'b000, 0, 2'd0, 4'd0, 3'b001, 3'b011, 0); // r16 ch0 sig
      add(3'b011, 3'b010, 3'b000, 0, 2'd0, 4'd0, 3'b000, 3'b011, 0); // r17
      add(3'b011, 3'b010, 3'b000, 0, 2'd0, 4'd0, 3'b010, 3'b001, 0); // r18 ch1 sig
      add(3'b011, 3'b010, 3'b000, 0, 2'd0, 4'd0, 3'b000, 3'b001, 0); // r19
      add(3'b011, 3'b010, 3'b000, 0, 2'd0, 4'd0, 3'b001, 3'b001, 0); // r20 ch0 sig

      // ---- reset state
      i_rst = 1'b1; i_en = '0; i_oneshot = '0; i_start = '0;
      i_cfg_valid = 1'b0; i_cfg_ch = '0; i_cfg_period = '0;
      #1;
      chk("reset cfg_ready", 32'(o_cfg_ready), 32'd0);
      chk("reset sig",       32'(o_sig),       32'd0);
      chk("reset flg",       32'(o_flg),       32'd0);
      chk("reset err",       32'(o_err),       32'd0);
      chk("reset cfg_err",   32'(o_cfg_err),   32'd0);
      cyc(); cyc();
      i_rst = 1'b0;
      cyc();
      chk("cfg_ready after release", 32'(o_cfg_ready), 32'd1);

      // ---- table
      for (int i = 0; i < tbl.size(); i++) begin
         i_en = tbl[i].en; i_oneshot = tbl[i].os; i_start = tbl[i].st;
         i_cfg_valid = tbl[i].cv; i_cfg_ch = tbl[i].ch; i_cfg_period = tbl[i].per;
         cyc();
         chk($sformatf("vec%0d sig", i),     32'(o_sig),     32'(tbl[i].sig));
         chk($sformatf("vec%0d flg", i),     32'(o_flg),     32'(tbl[i].flg));
         chk($sformatf("vec%0d err", i),     32'(o_err),     32'(tbl[i].err));
         chk($sformatf("vec%0d cfg_err", i), 32'(o_cfg_err), 32'(tbl[i].cerr));
      end
      i_start = '0; i_cfg_valid = 1'b0; i_oneshot = '0;

      // ---- period shrunk below the running count on ch2
      i_en = 3'b101;
      i_cfg_valid = 1'b1; i_cfg_ch = 2'd2; i_cfg_period = 4'd9;
      cyc();
      i_cfg_valid = 1'b0;
      i_start = 3'b100;
      cyc();
      i_start = '0;
      repeat (5) cyc();                       // ch2 cnt == 5
      chk("ch2 flg before shrink", 32'(o_flg[2]), 32'd1);
      i_cfg_valid = 1'b1; i_cfg_ch = 2'd2; i_cfg_period = 4'd3;
      cyc();
      i_cfg_valid = 1'b0;
      chk("shrink err pulse", 32'(o_err[2]), 32'd1);
      chk("shrink no sig",    32'(o_sig[2]), 32'd0);
      chk("shrink flg",       32'(o_flg[2]), 32'd1);
      cyc();
      chk("shrink err one cycle", 32'(o_err[2]), 32'd0);
      cyc(); cyc();
      chk("shrink sig not early", 32'(o_sig[2]), 32'd0);
      cyc();
      chk("shrink sig 4 after write", 32'(o_sig[2]), 32'd1);

      // ---- en gaps on ch2 (period 3): four enabled edges per sig
      i_start = 3'b100; i_en[2] = 1'b1;
      cyc();
      i_start = '0;
      en_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 7; k++) begin
         i_en[2] = en_pat[k];
         cyc();
         chk($sformatf("en gap step%0d sig", k), 32'(o_sig[2]), (k == 6) ? 32'd1 : 32'd0);
      end

      // ---- async reset mid-count
      i_en = 3'b101;
      cyc(); cyc();
      #2;
      i_rst = 1'b1;
      #1;
      chk("async rst sig",       32'(o_sig),       32'd0);
      chk("async rst flg",       32'(o_flg),       32'd0);
      chk("async rst err",       32'(o_err),       32'd0);
      chk("async rst cfg_ready", 32'(o_cfg_ready), 32'd0);
      cyc();
      chk("cfg_ready held in rst", 32'(o_cfg_ready), 32'd0);
      i_rst = 1'b0; i_en = '0;
      cyc();
      chk("cfg_ready after rst", 32'(o_cfg_ready), 32'd1);
      // ch1 had period 2; after reset it must be back to DEFAULT_N
      i_en = 3'b010; i_oneshot = '0; i_start = 3'b010;
      cyc();
      i_start = '0;
      chk("post rst flg ch1", 32'(o_flg[1]), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         cyc();
         chk($sformatf("post rst step%0d sig", k), 32'(o_sig[1]), (k == 4) ? 32'd1 : 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
